car_sensor_gen: RTL and testbench



---
 rtl/car_sensor_pkg.sv | 35 +++
 rtl/car_sensor_gen_dwell_timer.sv | 31 +++
 rtl/car_sensor_gen.sv | 117 +++++++++++
 tb/tb_car_sensor_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/car_sensor_pkg.sv
// car_sensor_pkg: shared phase encoding, direction and sensor-pair constants
// for the gate-sensor stimulus generator.
package car_sensor_pkg;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_A,
    PH_B,
    PH_C,
    PH_GAP
  } phase_t;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  // Sensor pairs written as {outer, inner}
  localparam logic [1:0] SNS_00 = 2'b00;
  localparam logic [1:0] SNS_10 = 2'b10;
  localparam logic [1:0] SNS_11 = 2'b11;
  localparam logic [1:0] SNS_01 = 2'b01;

  // Sensor pattern a car shows in a given phase for a given direction
  function automatic logic [1:0] phase_sns(input phase_t ph, input logic dir);
    logic [1:0] sns;
    sns = SNS_00;
    case (ph)
      PH_A:    sns = (dir == DIR_ENTER) ? SNS_10 : SNS_01;
      PH_B:    sns = SNS_11;
      PH_C:    sns = (dir == DIR_ENTER) ? SNS_01 : SNS_10;
      default: sns = SNS_00;
    endcase
    return sns;
  endfunction

endpackage

// File: rtl/car_sensor_gen_dwell_timer.sv
// dwell_timer: loadable down-counter that flags when a phase has run its
// programmed number of cycles. Load has priority over decrement.
module dwell_timer #(
  parameter int unsigned DW_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [DW_W-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  localparam logic [DW_W-1:0] ONE = DW_W'(1);

  logic [DW_W-1:0] cnt;

  // Reload on phase entry, otherwise count down and stick at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/car_sensor_gen.sv
// car_sensor_gen: plays the outer/inner photo-sensor sequence of a car
// entering or leaving the lot, one DWELL-cycle phase at a time, and keeps
// saturating counts of completed entries and exits.
// Build option CAR_SENSOR_GAP_EN inserts a DWELL-cycle idle gap after each car.
module car_sensor_gen
  import car_sensor_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned DW_W  = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  output logic             cmd_ready,
  output logic             outer,
  output logic             inner,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] enter_count,
  output logic [CNT_W-1:0] exit_count
);

  localparam logic [DW_W-1:0]  RELOAD  = DW_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  phase_t state, state_next;
  logic   dir, dir_next;
  logic   accept, load, dec, zero, finish;

  dwell_timer #(.DW_W(DW_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (RELOAD),
    .dec      (dec),
    .zero     (zero)
  );

  // Next phase, timer reload and completion strobe
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    accept     = cmd_valid && (state == PH_IDLE);
    dec        = (state != PH_IDLE);
    dir_next   = accept ? cmd_dir : dir;
    case (state)
      PH_IDLE: begin
        if (accept) begin
          state_next = PH_A;
          load       = 1'b1;
        end
      end
      PH_A: begin
        if (zero) begin
          state_next = PH_B;
          load       = 1'b1;
        end
      end
      PH_B: begin
        if (zero) begin
          state_next = PH_C;
          load       = 1'b1;
        end
      end
      PH_C: begin
        if (zero) begin
          finish = 1'b1;
          load   = 1'b1;
`ifdef CAR_SENSOR_GAP_EN
          state_next = PH_GAP;
`else
          state_next = PH_IDLE;
`endif
        end
      end
`ifdef CAR_SENSOR_GAP_EN
      PH_GAP: begin
        if (zero) begin
          state_next = PH_IDLE;
        end
      end
`endif
      default: state_next = PH_IDLE;
    endcase
  end

  // Outputs are registered from the next phase so they line up with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= PH_IDLE;
      dir            <= DIR_ENTER;
      {outer, inner} <= SNS_00;
      done           <= 1'b0;
      enter_count    <= '0;
      exit_count     <= '0;
    end else begin
      state          <= state_next;
      dir            <= dir_next;
      {outer, inner} <= phase_sns(state_next, dir_next);
      done           <= finish;
      if (finish && (dir == DIR_ENTER) && (enter_count != CNT_MAX)) begin
        enter_count <= enter_count + CNT_ONE;
      end
      if (finish && (dir == DIR_EXIT) && (exit_count != CNT_MAX)) begin
        exit_count <= exit_count + CNT_ONE;
      end
    end
  end

  assign cmd_ready = (state == PH_IDLE);
  assign busy      = !cmd_ready;

endmodule

// File: tb/tb_car_sensor_gen.sv
// tb_car_sensor_gen: directed tests of car_sensor_gen across several
// parameterisations sharing one clock and reset.
module tb_car_sensor_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  // Instance a: DWELL=2
  logic       cv_a = 1'b0, cd_a = 1'b0;
  logic       rdy_a, out_a, in_a, busy_a, done_a;
  logic [7:0] ec_a, xc_a;
  car_sensor_gen #(.DWELL(2), .DW_W(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cv_a), .cmd_dir(cd_a),
    .cmd_ready(rdy_a), .outer(out_a), .inner(in_a), .busy(busy_a),
    .done(done_a), .enter_count(ec_a), .exit_count(xc_a));

  // Instance b: DWELL=1
  logic       cv_b = 1'b0, cd_b = 1'b0;
  logic       rdy_b, out_b, in_b, busy_b, done_b;
  logic [7:0] ec_b, xc_b;
  car_sensor_gen #(.DWELL(1), .DW_W(8), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cv_b), .cmd_dir(cd_b),
    .cmd_ready(rdy_b), .outer(out_b), .inner(in_b), .busy(busy_b),
    .done(done_b), .enter_count(ec_b), .exit_count(xc_b));

  // Instance c: DWELL=1, 2-bit counters
  logic       cv_c = 1'b0, cd_c = 1'b0;
  logic       rdy_c, out_c, in_c, busy_c, done_c;
  logic [1:0] ec_c, xc_c;
  car_sensor_gen #(.DWELL(1), .DW_W(4), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .cmd_valid(cv_c), .cmd_dir(cd_c),
    .cmd_ready(rdy_c), .outer(out_c), .inner(in_c), .busy(busy_c),
    .done(done_c), .enter_count(ec_c), .exit_count(xc_c));

`ifdef CAR_SENSOR_GAP_EN
  // Instance g: DWELL=3 with the post-car gap
  logic       cv_g = 1'b0, cd_g = 1'b0;
  logic       rdy_g, out_g, in_g, busy_g, done_g;
  logic [7:0] ec_g, xc_g;
  car_sensor_gen #(.DWELL(3), .DW_W(8), .CNT_W(8)) dut_g (
    .clk(clk), .reset(reset), .cmd_valid(cv_g), .cmd_dir(cd_g),
    .cmd_ready(rdy_g), .outer(out_g), .inner(in_g), .busy(busy_g),
    .done(done_g), .enter_count(ec_g), .exit_count(xc_g));
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({out_a, in_a} !== 2'b00) begin bad++; $display("FAIL reset_sns: got %b exp 00", {out_a, in_a}); end
    total++;
    if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %b exp 0", done_a); end
    total++;
    if (rdy_a !== 1'b1 || busy_a !== 1'b0) begin bad++; $display("FAIL reset_ready: got rdy=%b busy=%b exp 1/0", rdy_a, busy_a); end
    total++;
    if (ec_a !== 8'd0 || xc_a !== 8'd0) begin bad++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", ec_a, xc_a); end
  endtask

  task automatic test_enter();
    logic [1:0] exp_sns [7] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
    cv_a = 1'b1;
    cd_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) cv_a = 1'b0;
      total++;
      if ({out_a, in_a} !== exp_sns[i]) begin bad++; $display("FAIL enter_sns[%0d]: got %b exp %b", i, {out_a, in_a}, exp_sns[i]); end
      total++;
      if (done_a !== (i == 6)) begin bad++; $display("FAIL enter_done[%0d]: got %b exp %b", i, done_a, (i == 6)); end
      total++;
      if (busy_a !== (i != 6)) begin bad++; $display("FAIL enter_busy[%0d]: got %b exp %b", i, busy_a, (i != 6)); end
      if (i == 5) begin
        total++;
        if (ec_a !== 8'd0) begin bad++; $display("FAIL enter_count_pre: got %0d exp 0", ec_a); end
      end
    end
    total++;
    if (ec_a !== 8'd1 || xc_a !== 8'd0) begin bad++; $display("FAIL enter_counts: got %0d/%0d exp 1/0", ec_a, xc_a); end
  endtask

  task automatic test_exit();
    logic [1:0] exp_sns [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    cv_b = 1'b1;
    cd_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) cv_b = 1'b0;
      total++;
      if ({out_b, in_b} !== exp_sns[i]) begin bad++; $display("FAIL exit_sns[%0d]: got %b exp %b", i, {out_b, in_b}, exp_sns[i]); end
      total++;
      if (done_b !== (i == 3)) begin bad++; $display("FAIL exit_done[%0d]: got %b exp %b", i, done_b, (i == 3)); end
    end
    total++;
    if (xc_b !== 8'd1 || ec_b !== 8'd0) begin bad++; $display("FAIL exit_counts: got exit=%0d enter=%0d exp 1/0", xc_b, ec_b); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_sns [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    logic       exp_rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    cv_b = 1'b1;
    cd_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      // After the enter is taken, keep valid up and flip to exit: it must wait
      if (i == 0) cd_b = 1'b1;
      if (i == 4) cv_b = 1'b0;
      total++;
      if ({out_b, in_b} !== exp_sns[i]) begin bad++; $display("FAIL b2b_sns[%0d]: got %b exp %b", i, {out_b, in_b}, exp_sns[i]); end
      total++;
      if (rdy_b !== exp_rdy[i]) begin bad++; $display("FAIL b2b_ready[%0d]: got %b exp %b", i, rdy_b, exp_rdy[i]); end
      total++;
      if (done_b !== exp_rdy[i]) begin bad++; $display("FAIL b2b_done[%0d]: got %b exp %b", i, done_b, exp_rdy[i]); end
      if (i == 3) begin
        total++;
        if (ec_b !== 8'd1 || xc_b !== 8'd1) begin bad++; $display("FAIL b2b_mid_counts: got %0d/%0d exp 1/1", ec_b, xc_b); end
      end
    end
    total++;
    if (ec_b !== 8'd1 || xc_b !== 8'd2) begin bad++; $display("FAIL b2b_counts: got %0d/%0d exp 1/2", ec_b, xc_b); end
  endtask

  task automatic test_reset_mid();
    cv_a = 1'b1;
    cd_a = 1'b0;
    tick();
    cv_a = 1'b0;
    tick();
    tick();
    total++;
    if ({out_a, in_a} !== 2'b11) begin bad++; $display("FAIL rmid_pre_sns: got %b exp 11", {out_a, in_a}); end
    // Valid coinciding with reset must not start a sequence
    reset = 1'b1;
    cv_a  = 1'b1;
    tick();
    reset = 1'b0;
    cv_a  = 1'b0;
    total++;
    if ({out_a, in_a} !== 2'b00) begin bad++; $display("FAIL rmid_sns: got %b exp 00", {out_a, in_a}); end
    total++;
    if (ec_a !== 8'd0 || xc_a !== 8'd0) begin bad++; $display("FAIL rmid_counts: got %0d/%0d exp 0/0", ec_a, xc_a); end
    total++;
    if (rdy_a !== 1'b1 || done_a !== 1'b0) begin bad++; $display("FAIL rmid_ready: got rdy=%b done=%b exp 1/0", rdy_a, done_a); end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (done_a !== 1'b0 || {out_a, in_a} !== 2'b00 || ec_a !== 8'd0) begin
        bad++;
        $display("FAIL rmid_quiet[%0d]: got done=%b sns=%b ec=%0d exp 0/00/0", i, done_a, {out_a, in_a}, ec_a);
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int n = 0; n < 5; n++) begin
      cv_c = 1'b1;
      cd_c = 1'b0;
      tick();
      cv_c = 1'b0;
      tick();
      tick();
      tick();
      total++;
      if (done_c !== 1'b1) begin bad++; $display("FAIL sat_done[%0d]: got %b exp 1", n, done_c); end
      total++;
      if (ec_c !== exp_ec[n] || xc_c !== 2'd0) begin bad++; $display("FAIL sat_count[%0d]: got %0d/%0d exp %0d/0", n, ec_c, xc_c, exp_ec[n]); end
    end
  endtask

`ifdef CAR_SENSOR_GAP_EN
  task automatic test_gap();
    cv_g = 1'b1;
    cd_g = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 0) cv_g = 1'b0;
      total++;
      if (rdy_g !== (i == 12)) begin bad++; $display("FAIL gap_ready[%0d]: got %b exp %b", i, rdy_g, (i == 12)); end
      if (i >= 9) begin
        total++;
        if ({out_g, in_g} !== 2'b00) begin bad++; $display("FAIL gap_sns[%0d]: got %b exp 00", i, {out_g, in_g}); end
      end
      total++;
      if (done_g !== (i == 9)) begin bad++; $display("FAIL gap_done[%0d]: got %b exp %b", i, done_g, (i == 9)); end
    end
    total++;
    if (ec_g !== 8'd1) begin bad++; $display("FAIL gap_count: got %0d exp 1", ec_g); end
  endtask
`endif

  initial begin
    test_reset();
    test_enter();
    test_exit();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
`ifdef CAR_SENSOR_GAP_EN
    test_gap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
